bcp_engine: RTL and testbench

BCP_ENGINE -- requirements
Module: bcp_engine

---
 rtl/bcp_engine_pkg.sv | 23 ++
 rtl/bcp_engine_fifo.sv | 53 +++++
 rtl/bcp_engine.sv | 170 +++++++++++++++++
 tb/tb_bcp_engine.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcp_engine_pkg.sv
// ============================================================================
// Module   : bcp_engine_pkg
// Brief    : Shared sizes and FSM state encoding for the BCP engine.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bcp_engine_pkg;

    localparam int MAX_VARS_BITS    = 8;
    localparam int MAX_CLAUSES_BITS = 8;
    // One literal is {neg, var}
    localparam int LIT_W            = MAX_VARS_BITS + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EVAL  = 2'd2
    } bcp_state_e;

endpackage

`default_nettype wire

// File: rtl/bcp_engine_fifo.sv
// ============================================================================
// Module   : bcp_fifo
// Brief    : Clause-index queue; power-of-2 depth, extra-MSB pointers.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Clear has priority so a flush drops any same-cycle push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (i_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_clr) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

    assign o_data  = r_mem[r_rptr[AW-1:0]];
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

`default_nettype wire

// File: rtl/bcp_engine.sv
// ============================================================================
// Module   : bcp_engine
// Brief    : Boolean constraint propagation: queues clause indices, fetches
//            each clause, classifies it as sat/unit/conflict/open.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcp_engine
    import bcp_engine_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LITS       = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_reset_bcp,
    input  logic                        i_clause_valid,
    input  logic [MAX_CLAUSES_BITS-1:0] i_clause_idx,
    output logic                        o_clause_ready,
    output logic                        o_cm_rd_en,
    output logic [MAX_CLAUSES_BITS-1:0] o_cm_rd_idx,
    input  logic [LITS*LIT_W-1:0]       i_cm_lits,
    output logic [MAX_VARS_BITS-1:0]    o_vs_var [LITS],
    input  logic [LITS-1:0]             i_vs_val,
    input  logic [LITS-1:0]             i_vs_unassign,
    output logic                        o_imply_push,
    output logic [MAX_VARS_BITS-1:0]    o_imply_var,
    output logic                        o_imply_val,
    output logic                        o_imply_type,
    input  logic                        i_imply_full,
    output logic                        o_bcp_busy,
    output logic                        o_conflict,
    output logic [MAX_CLAUSES_BITS-1:0] o_conflict_clause
);

    bcp_state_e                  r_state;
    logic [LITS*LIT_W-1:0]       r_lits;
    logic [MAX_CLAUSES_BITS-1:0] r_idx;
    logic                        r_conflict;
    logic [MAX_CLAUSES_BITS-1:0] r_conflict_clause;
    logic                        r_imply_push;
    logic [MAX_VARS_BITS-1:0]    r_imply_var;
    logic                        r_imply_val;
    logic                        r_imply_type;

    logic                        w_empty;
    logic                        w_full;
    logic [MAX_CLAUSES_BITS-1:0] w_head;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_flush;
    logic                        w_any_true;
    logic                        w_one_unas;
    logic                        w_multi_unas;
    logic [MAX_VARS_BITS-1:0]    w_unit_var;
    logic                        w_unit_neg;
    logic                        w_conf_hit;

    assign o_clause_ready = !w_full && !r_conflict;
    assign w_push         = i_clause_valid && o_clause_ready;
    // Read request is issued in the pop cycle so the word lands during FETCH
    assign w_pop          = (r_state == ST_IDLE) && !w_empty && !r_conflict && !i_reset_bcp;
    assign w_conf_hit     = (r_state == ST_EVAL) && !w_any_true && !w_one_unas;
    assign w_flush        = i_reset_bcp || w_conf_hit;

    bcp_fifo #(
        .WIDTH (MAX_CLAUSES_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_flush),
        .i_push  (w_push),
        .i_data  (i_clause_idx),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    generate
        for (genvar g = 0; g < LITS; g++) begin : g_vs_addr
            assign o_vs_var[g] = r_lits[g*LIT_W +: MAX_VARS_BITS];
        end
    endgenerate

    always_comb begin
        w_any_true   = 1'b0;
        w_one_unas   = 1'b0;
        w_multi_unas = 1'b0;
        w_unit_var   = '0;
        w_unit_neg   = 1'b0;
        for (int i = 0; i < LITS; i++) begin
            if (r_lits[i*LIT_W +: MAX_VARS_BITS] != '0) begin
                if (i_vs_unassign[i]) begin
                    w_multi_unas = w_multi_unas | w_one_unas;
                    w_one_unas   = 1'b1;
                    w_unit_var   = r_lits[i*LIT_W +: MAX_VARS_BITS];
                    w_unit_neg   = r_lits[i*LIT_W + MAX_VARS_BITS];
                end else if (i_vs_val[i] ^ r_lits[i*LIT_W + MAX_VARS_BITS]) begin
                    w_any_true = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= ST_IDLE;
            r_lits            <= '0;
            r_idx             <= '0;
            r_conflict        <= 1'b0;
            r_conflict_clause <= '0;
            r_imply_push      <= 1'b0;
            r_imply_var       <= '0;
            r_imply_val       <= 1'b0;
            r_imply_type      <= 1'b0;
        end else begin
            r_imply_push <= 1'b0;
            if (i_reset_bcp) begin
                r_state    <= ST_IDLE;
                r_conflict <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_pop) begin
                            r_idx   <= w_head;
                            r_state <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        r_lits  <= i_cm_lits;
                        r_state <= ST_EVAL;
                    end
                    ST_EVAL: begin
                        if (w_any_true || w_multi_unas) begin
                            r_state <= ST_IDLE;
                        end else if (!w_one_unas) begin
                            r_conflict        <= 1'b1;
                            r_conflict_clause <= r_idx;
                            r_state           <= ST_IDLE;
                        end else if (!i_imply_full) begin
                            // Unit clause: the lone open literal must become true
                            r_imply_push <= 1'b1;
                            r_imply_var  <= w_unit_var;
                            r_imply_val  <= ~w_unit_neg;
                            r_imply_type <= 1'b1;
                            r_state      <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_cm_rd_en        = w_pop;
    assign o_cm_rd_idx       = w_head;
    assign o_imply_push      = r_imply_push;
    assign o_imply_var       = r_imply_var;
    assign o_imply_val       = r_imply_val;
    assign o_imply_type      = r_imply_type;
    assign o_bcp_busy        = !w_empty || (r_state != ST_IDLE);
    assign o_conflict        = r_conflict;
    assign o_conflict_clause = r_conflict_clause;

endmodule

`default_nettype wire

// File: tb/tb_bcp_engine.sv
// ============================================================================
// Module   : tb_bcp_engine
// Brief    : Self-checking bench for bcp_engine with a clause-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bcp_engine;
    import bcp_engine_pkg::*;

    localparam int LITS    = 3;
    localparam int WW      = LITS * LIT_W;
    localparam int K_SAT   = 0;
    localparam int K_UNIT  = 1;
    localparam int K_CONF  = 2;
    localparam int K_MULTI = 3;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic                        reset_bcp = 1'b0;
    logic                        clause_valid = 1'b0;
    logic [MAX_CLAUSES_BITS-1:0] clause_idx = '0;
    logic                        clause_ready;
    logic                        cm_rd_en;
    logic [MAX_CLAUSES_BITS-1:0] cm_rd_idx;
    logic [WW-1:0]               cm_lits = '0;
    logic [MAX_VARS_BITS-1:0]    vs_var [LITS];
    logic [LITS-1:0]             vs_val;
    logic [LITS-1:0]             vs_unassign;
    logic                        imply_push;
    logic [MAX_VARS_BITS-1:0]    imply_var;
    logic                        imply_val;
    logic                        imply_type;
    logic                        imply_full = 1'b0;
    logic                        bcp_busy;
    logic                        conflict;
    logic [MAX_CLAUSES_BITS-1:0] conflict_clause;

    logic [WW-1:0] mem [256];
    bit            asg_val [256];
    bit            asg_una [256];

    int n_pass = 0;
    int n_total = 0;
    int push_cnt = 0;
    int push_vars [$];
    int rd_q [$];
    logic last_val;
    logic last_type;

    bcp_engine #(.FIFO_DEPTH(4), .LITS(LITS)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_reset_bcp       (reset_bcp),
        .i_clause_valid    (clause_valid),
        .i_clause_idx      (clause_idx),
        .o_clause_ready    (clause_ready),
        .o_cm_rd_en        (cm_rd_en),
        .o_cm_rd_idx       (cm_rd_idx),
        .i_cm_lits         (cm_lits),
        .o_vs_var          (vs_var),
        .i_vs_val          (vs_val),
        .i_vs_unassign     (vs_unassign),
        .o_imply_push      (imply_push),
        .o_imply_var       (imply_var),
        .o_imply_val       (imply_val),
        .o_imply_type      (imply_type),
        .i_imply_full      (imply_full),
        .o_bcp_busy        (bcp_busy),
        .o_conflict        (conflict),
        .o_conflict_clause (conflict_clause)
    );

    always #5 clk = ~clk;

    // Clause memory with one-cycle read latency
    always @(posedge clk) if (cm_rd_en) cm_lits <= mem[cm_rd_idx];

    always_comb begin
        for (int i = 0; i < LITS; i++) begin
            vs_val[i]      = asg_val[vs_var[i]];
            vs_unassign[i] = asg_una[vs_var[i]];
        end
    end

    always @(negedge clk) begin
        if (imply_push) begin
            push_cnt++;
            push_vars.push_back(int'(imply_var));
            last_val  = imply_val;
            last_type = imply_type;
        end
        if (cm_rd_en) rd_q.push_back(int'(cm_rd_idx));
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [LIT_W-1:0] lit(input bit n, input int v);
        return {n, MAX_VARS_BITS'(v)};
    endfunction

    // Clause outcome from literal truth values alone
    function automatic int model_eval(input logic [WW-1:0] w, output int uvar, output bit uval);
        int n_true;
        int unas [$];
        bit negs [$];
        int v;
        bit n;
        n_true = 0;
        uvar = 0;
        uval = 0;
        for (int i = 0; i < LITS; i++) begin
            v = int'(w[i*LIT_W +: MAX_VARS_BITS]);
            n = w[i*LIT_W + MAX_VARS_BITS];
            if (v != 0) begin
                if (asg_una[v]) begin
                    unas.push_back(v);
                    negs.push_back(n);
                end else if ((asg_val[v] && !n) || (!asg_val[v] && n)) begin
                    n_true++;
                end
            end
        end
        if (n_true > 0) return K_SAT;
        if (unas.size() == 0) return K_CONF;
        if (unas.size() == 1) begin
            uvar = unas[0];
            uval = !negs[0];
            return K_UNIT;
        end
        return K_MULTI;
    endfunction

    task automatic send(input int idx);
        clause_idx   = MAX_CLAUSES_BITS'(idx);
        clause_valid = 1'b1;
        @(negedge clk);
        clause_valid = 1'b0;
    endtask

    task automatic pulse_bcp();
        reset_bcp = 1'b1;
        @(negedge clk);
        reset_bcp = 1'b0;
    endtask

    task automatic run_one(input int idx);
        int kind;
        int uv;
        bit ub;
        int p0;
        kind = model_eval(mem[idx], uv, ub);
        p0 = push_cnt;
        check("ready_pre", clause_ready, 1);
        send(idx);
        @(negedge clk);
        @(negedge clk);
        check("busy_mid", bcp_busy, 1);
        @(negedge clk);
        check("busy_fall", bcp_busy, 0);
        @(negedge clk);
        check("push_count", push_cnt - p0, (kind == K_UNIT) ? 1 : 0);
        if (kind == K_UNIT) begin
            check("imply_var", push_vars[$], uv);
            check("imply_val", last_val, ub);
            check("imply_type", last_type, 1);
        end
        check("conflict", conflict, (kind == K_CONF) ? 1 : 0);
        if (kind == K_CONF) begin
            check("conflict_clause", conflict_clause, idx);
            check("ready_in_conflict", clause_ready, 0);
            pulse_bcp();
            check("conflict_cleared", conflict, 0);
            check("ready_after_clear", clause_ready, 1);
        end
    endtask

    initial begin
        int p0;
        int n;
        int found;
        logic [WW-1:0] w;

        repeat (2) @(negedge clk);
        check("rst_ready", clause_ready, 1);
        check("rst_busy", bcp_busy, 0);
        check("rst_conflict", conflict, 0);
        check("rst_cclause", conflict_clause, 0);
        check("rst_push", imply_push, 0);
        check("rst_rd_en", cm_rd_en, 0);
        rst_n = 1'b1;

        // (x1 v ~x2 v x3) with x1=1: satisfied
        asg_val[1] = 1; asg_una[1] = 0; asg_una[2] = 1; asg_una[3] = 1;
        mem[1] = {lit(0, 3), lit(1, 2), lit(0, 1)};
        p0 = push_cnt;
        run_one(1);
        check("sat_nopush", push_cnt - p0, 0);

        // (~x4 v x5), x4=1, x5 open -> imply x5=1
        asg_val[4] = 1; asg_una[4] = 0; asg_una[5] = 1;
        mem[2] = {lit(0, 0), lit(0, 5), lit(1, 4)};
        run_one(2);
        check("unit_var5", push_vars[$], 5);

        // (x2 v x3) all false at idx 7; queued clause 8 must be flushed unread
        asg_val[2] = 0; asg_una[2] = 0; asg_val[3] = 0; asg_una[3] = 0;
        mem[7] = {lit(0, 0), lit(0, 3), lit(0, 2)};
        mem[8] = {lit(0, 0), lit(0, 0), lit(0, 1)};
        rd_q.delete();
        send(7);
        send(8);
        @(negedge clk);
        @(negedge clk);
        check("c7_conflict", conflict, 1);
        check("c7_cclause", conflict_clause, 7);
        check("c7_ready", clause_ready, 0);
        repeat (3) @(negedge clk);
        found = 0;
        foreach (rd_q[j]) if (rd_q[j] == 8) found++;
        check("c8_never_read", found, 0);
        check("c7_busy", bcp_busy, 0);
        pulse_bcp();
        check("c7_cleared", conflict, 0);

        // Unit clause stalled by imply_full for 5 EVAL cycles
        asg_una[9] = 1;
        mem[3] = {lit(0, 0), lit(0, 0), lit(1, 9)};
        imply_full = 1'b1;
        p0 = push_cnt;
        send(3);
        repeat (7) @(negedge clk);
        check("hold_nopush", push_cnt - p0, 0);
        check("hold_busy", bcp_busy, 1);
        imply_full = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("hold_onepush", push_cnt - p0, 1);
        check("hold_var", push_vars[$], 9);
        check("hold_val", last_val, 0);

        // Five offers into a depth-4 queue while the engine is stalled
        for (int k = 20; k <= 25; k++) asg_una[k] = 1;
        mem[9] = {lit(0, 0), lit(0, 0), lit(0, 20)};
        for (int k = 0; k < 5; k++) mem[10+k] = {lit(0, 0), lit(0, 0), lit(0, 21 + k)};
        push_vars.delete();
        rd_q.delete();
        imply_full = 1'b1;
        send(9);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            clause_idx   = MAX_CLAUSES_BITS'(10 + k);
            clause_valid = 1'b1;
            check("fill_ready", clause_ready, (k < 4) ? 1 : 0);
            if (k < 4) @(negedge clk);
        end
        imply_full = 1'b0;
        n = 0;
        while (!clause_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("fill_wait_bound", (n < 20) ? 1 : 0, 1);
        @(negedge clk);
        clause_valid = 1'b0;
        n = 0;
        while (bcp_busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("fill_drain_bound", (n < 60) ? 1 : 0, 1);
        check("fill_push_count", push_vars.size(), 6);
        check("fill_rd_count", rd_q.size(), 6);
        for (int j = 0; j < 6; j++) begin
            if (j < push_vars.size()) check("fill_push_order", push_vars[j], 20 + j);
            if (j < rd_q.size()) check("fill_rd_order", rd_q[j], 9 + j);
        end

        // reset_bcp while the first clause sits in FETCH and a second is queued
        asg_una[30] = 1; asg_una[31] = 1;
        mem[4] = {lit(0, 0), lit(0, 0), lit(0, 30)};
        mem[5] = {lit(0, 0), lit(0, 0), lit(0, 31)};
        p0 = push_cnt;
        send(4);
        send(5);
        pulse_bcp();
        check("abort_busy", bcp_busy, 0);
        repeat (4) @(negedge clk);
        check("abort_nopush", push_cnt - p0, 0);
        check("abort_busy_late", bcp_busy, 0);
        check("abort_ready", clause_ready, 1);

        // Random clauses against random assignments
        for (int it = 0; it < 40; it++) begin
            for (int v = 1; v < 16; v++) begin
                asg_una[v] = ($urandom % 3) == 0;
                asg_val[v] = $urandom % 2;
            end
            for (int s = 0; s < LITS; s++) begin
                n = (($urandom % 4) == 0) ? 0 : int'($urandom_range(1, 15));
                w[s*LIT_W +: LIT_W] = lit($urandom % 2, n);
            end
            n = int'($urandom_range(0, 255));
            mem[n] = w;
            run_one(n);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
